// File: rtl/div19s_by_8s.sv
// div19s_by_8s
//   Iterative signed divider: 19-bit signed dividend / 8-bit signed divisor ->
//   11-bit saturating signed quotient + 8-bit signed remainder (sign of num).
//   Sign-magnitude internally, restoring division, one quotient bit per clock.
//   Fixed latency: out_valid rises NUM_W+1 edges after the accept edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   num/den valid
//   in_ready   block can accept (high only in IDLE)
//   num        signed dividend   [NUM_W-1:0]
//   den        signed divisor    [DEN_W-1:0]
//   out_valid  quo/rem/flags valid, held until out_ready
//   out_ready  downstream accepts result
//   quo        signed quotient   [QUO_W-1:0], saturating
//   rem        signed remainder  [DEN_W-1:0], |rem| < |den|
//   ovf        quotient saturated
//   div_zero   divisor was zero
//
// Configuration
//   DIV_ROUND_EN  defined: quotient rounded half away from zero (rem stays truncated).
//                 undefined: quotient truncated toward zero.

module div19s_by_8s #(
    parameter int NUM_W = 19,
    parameter int DEN_W = 8,
    parameter int QUO_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QUO_W-1:0] quo,
    output logic [DEN_W-1:0] rem,
    output logic             ovf,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(NUM_W);

    localparam logic [QUO_W-1:0] QUO_POS = {1'b0, {(QUO_W-1){1'b1}}};
    localparam logic [QUO_W-1:0] QUO_NEG = {1'b1, {(QUO_W-1){1'b0}}};
    localparam logic [NUM_W:0]   POS_LIM = {{(NUM_W+1-QUO_W){1'b0}}, QUO_POS};
    localparam logic [NUM_W:0]   NEG_LIM = {{(NUM_W+1-QUO_W){1'b0}}, QUO_NEG};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // num_mag doubles as the dividend shifter and the quotient accumulator:
    // dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [NUM_W-1:0] num_mag;
    logic [DEN_W-1:0] den_mag;
    logic [DEN_W-1:0] prem;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    // Restoring step
    logic [DEN_W:0]   shifted;
    logic             sub;
    logic [DEN_W-1:0] diff;

    // Sign / saturation stage
    logic [NUM_W:0]   q_mag;
    logic [QUO_W-1:0] quo_fix;
    logic [DEN_W-1:0] rem_fix;
    logic             ovf_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = CALC;
            CALC: if (cnt == '0) state_next = FIX;
            FIX:                 state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ restoring step
    // The partial remainder is always < |den| <= 2^(DEN_W-1), so the shifted
    // value fits in DEN_W+1 bits and the difference fits back in DEN_W bits.
    always_comb begin
        shifted = {prem, num_mag[NUM_W-1]};
        sub     = (shifted >= {1'b0, den_mag});
        diff    = shifted[DEN_W-1:0] - den_mag;
    end

    // ----------------------------------------------- sign and saturation
    always_comb begin
        q_mag   = {1'b0, num_mag};
        quo_fix = '0;
        rem_fix = sign_r ? -prem : prem;
        ovf_fix = 1'b0;
`ifdef DIV_ROUND_EN
        if (!dz && ({prem, 1'b0} >= {1'b0, den_mag}))
            q_mag = q_mag + 1'b1;
`endif
        if (dz) begin
            quo_fix = sign_r ? QUO_NEG : QUO_POS;
            rem_fix = '0;
        end else if (!sign_q) begin
            if (q_mag > POS_LIM) begin
                quo_fix = QUO_POS;
                ovf_fix = 1'b1;
            end else begin
                quo_fix = q_mag[QUO_W-1:0];
            end
        end else begin
            if (q_mag > NEG_LIM) begin
                quo_fix = QUO_NEG;
                ovf_fix = 1'b1;
            end else begin
                // Magnitude 2^(QUO_W-1) negates onto itself, which is the
                // most negative code, so no special case is needed.
                quo_fix = -q_mag[QUO_W-1:0];
            end
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_mag  <= '0;
            den_mag  <= '0;
            prem     <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz       <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        num_mag <= num[NUM_W-1] ? -num : num;
                        den_mag <= den[DEN_W-1] ? -den : den;
                        sign_q  <= num[NUM_W-1] ^ den[DEN_W-1];
                        sign_r  <= num[NUM_W-1];
                        dz      <= (den == '0);
                        prem    <= '0;
                        cnt     <= CNT_W'(NUM_W - 1);
                    end
                end
                CALC: begin
                    prem    <= sub ? diff : shifted[DEN_W-1:0];
                    num_mag <= {num_mag[NUM_W-2:0], sub};
                    cnt     <= cnt - 1'b1;
                end
                FIX: begin
                    quo      <= quo_fix;
                    rem      <= rem_fix;
                    ovf      <= ovf_fix;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule
